// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared prescaled timebase, edge/center modes
// and double-buffered period/mode/duty committed only at period boundaries.
module pwm_multi #(
    parameter int N  = 9,
    parameter int CH = 4,
    parameter int PW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [PW-1:0]   prescale_in,
    input  logic [N-1:0]    period_in,
    input  logic            center_in,
    input  logic [CH*N-1:0] duty_in,
    input  logic            upd_valid,
    output logic            upd_ready,
    output logic [CH-1:0]   pwm_out,
    output logic [N-1:0]    count_out,
    output logic            period_end
);
    logic [PW-1:0]   psc;
    logic [N-1:0]    cnt, cnt_inc, stg_period, act_period;
    logic            down, pending, stg_center, act_center, tick, bnd;
    logic [CH*N-1:0] stg_duty, act_duty;
    logic [CH-1:0]   cmp;
    assign upd_ready = !pending;
    assign count_out = cnt;
    // down means the next step decrements; it is set on arrival at P so the
    // boundary test (down at count 1) also covers P=1 in center mode
    always_comb begin
        tick    = enable && (psc == prescale_in);
        cnt_inc = cnt + N'(1);
        bnd     = tick && (act_period == '0 || (act_center ? (down && cnt == N'(1)) : (cnt == act_period)));
        cmp     = '0;
        for (int i = 0; i < CH; i++)
            cmp[i] = cnt < act_duty[i*N +: N];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc        <= '0;
            cnt        <= '0;
            down       <= 1'b0;
            pending    <= 1'b0;
            stg_period <= '0;
            stg_center <= 1'b0;
            stg_duty   <= '0;
            act_period <= '1;
            act_center <= 1'b0;
            act_duty   <= '0;
            pwm_out    <= '0;
            period_end <= 1'b0;
        end else begin
            psc <= (tick || !enable) ? '0 : psc + PW'(1);
            if (!enable || bnd) begin
                cnt  <= '0;
                down <= 1'b0;
            end else if (tick) begin
                cnt  <= down ? cnt - N'(1) : cnt_inc;
                down <= act_center && (down || cnt_inc == act_period);
            end
            if (upd_valid && !pending) begin
                stg_period <= period_in;
                stg_center <= center_in;
                stg_duty   <= duty_in;
                pending    <= 1'b1;
            end else if (pending && (bnd || !enable)) begin
                act_period <= stg_period;
                act_center <= stg_center;
                act_duty   <= stg_duty;
                pending    <= 1'b0;
            end
            pwm_out    <= enable ? cmp : '0;
            period_end <= bnd;
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed table-driven bench for pwm_multi plus multi-cycle
// sequences for defaults, double buffering, center counting, enable and reset.
module tb_pwm_multi;
    localparam int N = 9, CH = 4, PW = 8;
    logic            clk = 0, reset = 1, enable = 0, center_in = 0, upd_valid = 0;
    logic [PW-1:0]   prescale_in = '0;
    logic [N-1:0]    period_in = '0;
    logic [CH*N-1:0] duty_in = '0;
    logic            upd_ready, period_end;
    logic [CH-1:0]   pwm_out;
    logic [N-1:0]    count_out;
    int tests = 0, fails = 0;

    typedef struct {
        int p;
        int c;
        int psc;
        int d[4];
        int len;
        int h[4];
    } vec_t;
    vec_t vecs[6];

    pwm_multi #(.N(N), .CH(CH), .PW(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .prescale_in(prescale_in),
        .period_in(period_in), .center_in(center_in), .duty_in(duty_in),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .pwm_out(pwm_out),
        .count_out(count_out), .period_end(period_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic stage(input int p, input int c, input int psc, input int d0, input int d1, input int d2, input int d3);
        int t = 0;
        while (!upd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("stage_ready", int'(upd_ready), 1);
        period_in   = N'(p);
        center_in   = c[0];
        prescale_in = PW'(psc);
        duty_in     = {N'(d3), N'(d2), N'(d1), N'(d0)};
        upd_valid   = 1;
        @(negedge clk);
        upd_valid = 0;
    endtask

    task automatic wait_commit();
        int t = 0;
        while (!upd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("commit", int'(upd_ready), 1);
    endtask

    initial begin
        int pe1, pe2, hi, h[4], pe_n, last, h0a, h0b;
        int seq[8];
        vecs[0] = '{p:9, c:0, psc:0, d:'{3, 0, 10, 9}, len:10, h:'{3, 0, 10, 9}};
        vecs[1] = '{p:4, c:1, psc:0, d:'{2, 0, 5, 1},  len:8,  h:'{3, 0, 8, 1}};
        vecs[2] = '{p:3, c:0, psc:2, d:'{2, 4, 1, 3},  len:12, h:'{6, 12, 3, 9}};
        vecs[3] = '{p:0, c:0, psc:0, d:'{1, 0, 0, 0},  len:1,  h:'{1, 0, 0, 0}};
        vecs[4] = '{p:1, c:1, psc:0, d:'{1, 2, 0, 0},  len:2,  h:'{1, 2, 0, 0}};
        vecs[5] = '{p:5, c:1, psc:1, d:'{3, 6, 0, 4},  len:20, h:'{10, 20, 0, 14}};
        seq = '{0, 1, 2, 3, 4, 3, 2, 1};

        @(negedge clk);
        check("rst_count", int'(count_out), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_pe", int'(period_end), 0);
        check("rst_ready", int'(upd_ready), 1);
        reset  = 0;
        enable = 1;
        pe1 = 0; pe2 = 0; hi = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            hi += $countones(pwm_out);
            if (period_end) begin
                if (pe1 == 0) pe1 = i;
                else if (pe2 == 0) pe2 = i;
            end
            if (i == 511) check("def_count_max", int'(count_out), 511);
        end
        check("def_pe1", pe1, 512);
        check("def_pe2", pe2, 1024);
        check("def_pwm_low", hi, 0);

        foreach (vecs[v]) begin
            stage(vecs[v].p, vecs[v].c, vecs[v].psc, vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
            wait_commit();
            h = '{0, 0, 0, 0};
            pe_n = 0; last = 0;
            for (int k = 1; k <= 2 * vecs[v].len; k++) begin
                @(negedge clk);
                for (int c = 0; c < CH; c++) h[c] += int'(pwm_out[c]);
                pe_n += int'(period_end);
                if (k == 2 * vecs[v].len) last = int'(period_end);
            end
            for (int c = 0; c < CH; c++) check($sformatf("vec%0d_ch%0d_high", v, c), h[c], 2 * vecs[v].h[c]);
            check($sformatf("vec%0d_pe_count", v), pe_n, 2);
            check($sformatf("vec%0d_pe_last", v), last, 1);
        end

        stage(9, 0, 0, 3, 0, 10, 9);
        wait_commit();
        h0a = 0; h0b = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 10) h0a += int'(pwm_out[0]);
            else h0b += int'(pwm_out[0]);
            if (k == 4) begin
                check("db_count4", int'(count_out), 4);
                duty_in[0 +: N] = N'(7);
                upd_valid = 1;
            end
            if (k == 5) begin
                upd_valid = 0;
                check("db_ready_lo5", int'(upd_ready), 0);
            end
            if (k == 9) check("db_ready_lo9", int'(upd_ready), 0);
            if (k == 10) check("db_ready_hi10", int'(upd_ready), 1);
        end
        check("db_old_period", h0a, 3);
        check("db_new_period", h0b, 7);

        stage(4, 1, 0, 2, 0, 0, 0);
        wait_commit();
        for (int j = 0; j < 16; j++) begin
            check($sformatf("ctr_seq%0d", j), int'(count_out), seq[j % 8]);
            check($sformatf("ctr_pe%0d", j), int'(period_end), int'(j % 8 == 0));
            @(negedge clk);
        end

        enable = 0;
        @(negedge clk);
        check("en_low_count", int'(count_out), 0);
        check("en_low_pwm", int'(pwm_out), 0);
        check("en_low_pe", int'(period_end), 0);
        stage(9, 0, 0, 3, 0, 10, 9);
        @(negedge clk);
        check("en_low_commit", int'(upd_ready), 1);
        enable = 1;
        for (int t = 0; t < 100 && count_out != 3; t++) @(negedge clk);
        stage(20, 0, 0, 1, 1, 1, 1);
        @(negedge clk);
        check("ar_count5", int'(count_out), 5);
        check("ar_pwm_pre", int'(pwm_out), 12);
        #2 reset = 1;
        #1;
        check("ar_count", int'(count_out), 0);
        check("ar_pwm", int'(pwm_out), 0);
        #1 reset = 0;
        check("ar_ready", int'(upd_ready), 1);
        pe1 = 0; hi = 0;
        for (int i = 1; i <= 600 && pe1 == 0; i++) begin
            @(negedge clk);
            hi += $countones(pwm_out);
            if (period_end) pe1 = i;
        end
        check("ar_period_511", pe1, 512);
        check("ar_pwm_low", hi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator with one shared timebase and CH independent duty channels. It adds a programmable period, a clock prescaler, and an edge-aligned or center-aligned counting mode. Period, mode and all duties are double-buffered: a staging set is written through a valid/ready handshake and committed only at a period boundary, so no output ever emits a partial period. It sits between the register/control logic and the output pads, replacing the single-channel fixed-period PWM.

## Interface

- N, 9: counter, period and duty width.
- CH, 4: number of PWM channels.
- PW, 8: prescaler width.

- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  timebase run; low holds counter/prescaler at 0, outputs low.
- prescale_in  input  PW  tick every prescale_in+1 clocks; sampled live, not buffered.
- period_in  input  N  staged period P; edge mode runs 0..P.
- center_in  input  1  staged mode: 0 = edge-aligned, 1 = center-aligned.
- duty_in  input  CH*N  staged duties; channel i at bits [i*N +: N].
- upd_valid  input  1  staging write request.
- upd_ready  output  1  staging register free.
- pwm_out  output  CH  registered PWM outputs.
- count_out  output  N  current timebase count.
- period_end  output  1  one-clock pulse, registered, coincident with first count 0 of a new period.

## Operation

- Reset values: count_out=0, direction=up, prescaler=0, pwm_out=0, period_end=0, upd_ready=1, pending=0.
- Reset values (active set): P=2^N-1, mode=edge, all duties 0.
- Prescaler:
  - Counts 0..prescale_in.
  - tick = (prescaler==prescale_in) && enable.
  - prescale_in=0 gives a tick every clock.
- Edge mode: on each tick, count increments. At count==P the next value is 0.
  - Boundary B = tick && count==P.
  - Period length = P+1 ticks.
- Center mode: count goes 0,1..P, then P-1..1, then 0; direction flips at P and at 1 (down).
  - Boundary B = tick && dir==down && count==1.
  - Period length = 2P ticks.
- P=0, either mode: count holds 0 and B occurs on every tick.
- Handshake:
  - upd_valid && upd_ready captures period_in, center_in and duty_in into staging and sets pending.
  - upd_ready goes low from the next cycle.
- Commit: at B with pending, staging is copied to the active set, the counter goes to 0, dir goes up, and pending clears.
  - upd_ready returns high the following cycle.
  - A mode change always restarts at count 0, direction up.
- Simultaneous capture and B in the same cycle: the captured values are staged only and commit at the next B.
- enable low: counter, dir and prescaler held at reset values; pwm_out=0; period_end=0. Any pending staging commits on the next clock.
- Output compare: pwm_out[i] <= enable && (count_out < duty_act[i]), unsigned N-bit.
  - duty 0: constantly low.
  - duty > P: constantly high (edge mode).
  - Center mode: high interval is symmetric about count 0.
- period_end <= B; it is never asserted while enable is low.

## Timing

- pwm_out lags count_out by exactly one clock.
- Staged values take effect on the first count 0 after the next B. Worst case latency is one full period plus one clock after the handshake.
- The active set changes only at B, never mid-period.
- prescale_in changes take effect at the next prescaler wrap; the counter is not reset.
- Asynchronous reset mid-period: outputs go low immediately and staging is discarded. After deassertion, counting resumes from 0 on the first tick.
- enable rising: the first tick occurs after prescale_in+1 clocks. count_out=0 for that whole interval.

## Test plan

- Reset and defaults: assert reset, release, enable=1, prescale_in=0, no update -> count_out runs 0..511 and wraps; pwm_out all 0; period_end pulses every 512 clocks.
- Edge duty: update P=9, edge, duty ch0=3, ch1=0, ch2=10, ch3=9 -> after commit, over 10 clocks ch0 high 3, ch1 high 0, ch2 high 10, ch3 high 9; period_end every 10 clocks.
- Double-buffering: running at P=9, duty ch0=3; stage duty ch0=7 at count 4 -> current period keeps 3 high. Next period has 7 high. upd_ready is low from capture until the clock after B.
- Center mode: P=4, duty ch0=2 -> count sequence 0,1,2,3,4,3,2,1 repeating; ch0 high for 3 of every 8 clocks; period_end every 8 clocks.
- Prescaler: prescale_in=2, P=3 edge -> each count value held 3 clocks; period 12 clocks; duty 2 gives 6 high clocks.
- Async reset mid-operation: pulse reset between clock edges at count 5 with pending update -> pwm_out and count_out are 0 before the next edge; pending is dropped; P reverts to 511.
